// File: rtl/fft_pkg.sv
// Shared widths, twiddle constant, bit-reverse order and complex sample type
// for the 8-point DIT FFT datapath.
package fft_pkg;

    localparam int DW     = 8;
    localparam int IW     = 12;
    localparam int TW_Q   = 7;
    localparam int OUT_SH = 3;

    localparam logic signed [7:0] COS45_Q7 = 8'sd91;

    // Entry p is the natural-order sample index feeding stage-1 position p.
    localparam logic [7:0][2:0] BITREV = {3'd7, 3'd3, 3'd5, 3'd1,
                                          3'd6, 3'd2, 3'd4, 3'd0};

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_t;

    // Floor-rounded v * 91/128; the result always fits IW for in-range data.
    function automatic logic signed [IW-1:0] mul_cos45(input logic signed [IW-1:0] v);
        logic signed [IW+7:0] p;
        p = v * COS45_Q7;
        return p[TW_Q +: IW];
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly: o_top = a + W*b, o_bot = a - W*b, with W8^TW_IDX
// fixed at elaboration (W0 pass-through, W2 swap/negate, W1/W3 via cos(pi/4)).
module fft_butterfly
    import fft_pkg::*;
#(
    parameter logic [1:0] TW_IDX = 2'd0
) (
    input  cplx_t i_a,
    input  cplx_t i_b,
    output cplx_t o_top,
    output cplx_t o_bot
);

    cplx_t w_wb;

    generate
        if (TW_IDX == 2'd0) begin : g_w0
            assign w_wb = i_b;
        end else if (TW_IDX == 2'd2) begin : g_w2
            assign w_wb.re = i_b.im;
            assign w_wb.im = -i_b.re;
        end else begin : g_wodd
            logic signed [IW-1:0] w_pr;
            logic signed [IW-1:0] w_pi;

            // Each component is scaled and rounded before the add/sub.
            assign w_pr = mul_cos45(i_b.re);
            assign w_pi = mul_cos45(i_b.im);

            if (TW_IDX == 2'd1) begin : g_w1
                assign w_wb.re = w_pr + w_pi;
                assign w_wb.im = w_pi - w_pr;
            end else begin : g_w3
                assign w_wb.re = w_pi - w_pr;
                assign w_wb.im = -w_pr - w_pi;
            end
        end
    endgenerate

    assign o_top.re = i_a.re + w_wb.re;
    assign o_top.im = i_a.im + w_wb.im;
    assign o_bot.re = i_a.re - w_wb.re;
    assign o_bot.im = i_a.im - w_wb.im;

endmodule

// File: rtl/fft_datapath.sv
// Fully pipelined 8-point radix-2 DIT FFT: three butterfly stages, each registered,
// one real vector in per clock, Re(X[k]) >>> 3 out three clocks later.
module fft_datapath
    import fft_pkg::*;
(
    input  logic                 clk_1,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] in1,
    input  logic signed [DW-1:0] in2,
    input  logic signed [DW-1:0] in3,
    input  logic signed [DW-1:0] in4,
    input  logic signed [DW-1:0] in5,
    input  logic signed [DW-1:0] in6,
    input  logic signed [DW-1:0] in7,
    input  logic signed [DW-1:0] in8,
    output logic signed [DW-1:0] out1,
    output logic signed [DW-1:0] out2,
    output logic signed [DW-1:0] out3,
    output logic signed [DW-1:0] out4,
    output logic signed [DW-1:0] out5,
    output logic signed [DW-1:0] out6,
    output logic signed [DW-1:0] out7,
    output logic signed [DW-1:0] out8
);

    logic signed [DW-1:0] w_x [8];
    logic signed [DW-1:0] w_y [8];
    cplx_t                w_stin  [3][8];
    cplx_t                w_bf    [3][8];
    cplx_t                r_stage [3][8];

    assign w_x[0] = in1;
    assign w_x[1] = in2;
    assign w_x[2] = in3;
    assign w_x[3] = in4;
    assign w_x[4] = in5;
    assign w_x[5] = in6;
    assign w_x[6] = in7;
    assign w_x[7] = in8;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign w_stin[0][gi] = '{re: IW'(w_x[BITREV[gi]]), im: '0};
            assign w_stin[1][gi] = r_stage[0][gi];
            assign w_stin[2][gi] = r_stage[1][gi];
            assign w_y[gi]       = r_stage[2][gi].re[OUT_SH +: DW];
        end

        // Stage gi pairs elements SPAN apart; the twiddle step shrinks as the span grows.
        for (gi = 0; gi < 3; gi++) begin : g_stage
            localparam int SPAN = 1 << gi;
            for (gj = 0; gj < 4; gj++) begin : g_bf
                localparam int         OFF = gj % SPAN;
                localparam int         TOP = (gj / SPAN) * 2 * SPAN + OFF;
                localparam int         BOT = TOP + SPAN;
                localparam logic [1:0] TW  = 2'(OFF << (2 - gi));

                fft_butterfly #(
                    .TW_IDX (TW)
                ) u_bf (
                    .i_a   (w_stin[gi][TOP]),
                    .i_b   (w_stin[gi][BOT]),
                    .o_top (w_bf[gi][TOP]),
                    .o_bot (w_bf[gi][BOT])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < 8; k++) begin
                    r_stage[s][k] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < 8; k++) begin
                    r_stage[s][k] <= w_bf[s][k];
                end
            end
        end
    end

    assign out1 = w_y[0];
    assign out2 = w_y[1];
    assign out3 = w_y[2];
    assign out4 = w_y[3];
    assign out5 = w_y[4];
    assign out6 = w_y[5];
    assign out7 = w_y[6];
    assign out8 = w_y[7];

endmodule

// File: tb/tb_fft_datapath.sv
// Self-checking bench for fft_datapath: directed spectra plus random vectors,
// each compared three clocks later against an iterative integer FFT model.
module tb_fft_datapath;

    logic              clk_1 = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] in1, in2, in3, in4, in5, in6, in7, in8;
    logic signed [7:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [7:0]        w_out [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs of the vectors currently in flight; index 2 is due next.
    logic [7:0] p_mdl [3][8];
    logic [7:0] p_spc [3][8];
    logic [7:0] p_msk [3];

    always #5 clk_1 = ~clk_1;

    fft_datapath u_dut (
        .clk_1 (clk_1), .rst_n (rst_n),
        .in1 (in1), .in2 (in2), .in3 (in3), .in4 (in4),
        .in5 (in5), .in6 (in6), .in7 (in7), .in8 (in8),
        .out1 (out1), .out2 (out2), .out3 (out3), .out4 (out4),
        .out5 (out5), .out6 (out6), .out7 (out7), .out8 (out8)
    );

    assign w_out[0] = out1;
    assign w_out[1] = out2;
    assign w_out[2] = out3;
    assign w_out[3] = out4;
    assign w_out[4] = out5;
    assign w_out[5] = out6;
    assign w_out[6] = out7;
    assign w_out[7] = out8;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Textbook in-place radix-2 DIT FFT with 91/128 floor-rounded odd twiddles.
    function automatic void fft_ref(input int x[8], output logic [7:0] y[8]);
        int re [8];
        int im [8];
        int a, b, e, half, br, bi, tr, ti, pr, pim, sr, ar, ai;
        for (int i = 0; i < 8; i++) begin
            re[i] = x[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)];
            im[i] = 0;
        end
        for (int len = 2; len <= 8; len = len * 2) begin
            half = len / 2;
            for (int st = 0; st < 8; st += len) begin
                for (int k = 0; k < half; k++) begin
                    a  = st + k;
                    b  = a + half;
                    e  = k * (8 / len);
                    br = re[b];
                    bi = im[b];
                    if (e == 0) begin
                        tr = br;
                        ti = bi;
                    end else if (e == 2) begin
                        tr = bi;
                        ti = -br;
                    end else begin
                        pr  = (br * 91) >>> 7;
                        pim = (bi * 91) >>> 7;
                        sr  = (e == 1) ? 1 : -1;
                        tr  = sr * pr + pim;
                        ti  = -pr + sr * pim;
                    end
                    ar = re[a];
                    ai = im[a];
                    re[a] = ar + tr;
                    im[a] = ai + ti;
                    re[b] = ar - tr;
                    im[b] = ai - ti;
                end
            end
        end
        for (int k = 0; k < 8; k++) y[k] = 8'(re[k] >>> 3);
    endfunction

    task automatic drive(input int x[8]);
        in1 = 8'(x[0]); in2 = 8'(x[1]); in3 = 8'(x[2]); in4 = 8'(x[3]);
        in5 = 8'(x[4]); in6 = 8'(x[5]); in7 = 8'(x[6]); in8 = 8'(x[7]);
    endtask

    // One clock: check the vector due now, then present x (or hold reset).
    task automatic cycle(input int x[8], input int s[8], input logic [7:0] msk, input bit rst);
        logic [7:0] y [8];
        @(negedge clk_1);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("model_out%0d t=%0t", k + 1, $time), w_out[k], p_mdl[2][k]);
            if (p_msk[2][k])
                check_eq($sformatf("spec_out%0d t=%0t", k + 1, $time), w_out[k], p_spc[2][k]);
        end
        $display("[TB] t=%0t rst_n=%0b out={%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d}", $time, rst_n,
                 out1, out2, out3, out4, out5, out6, out7, out8);
        for (int d = 2; d > 0; d--) begin
            for (int k = 0; k < 8; k++) begin
                p_mdl[d][k] = p_mdl[d-1][k];
                p_spc[d][k] = p_spc[d-1][k];
            end
            p_msk[d] = p_msk[d-1];
        end
        drive(x);
        if (rst) begin
            if (rst_n) begin
                rst_n = 1'b0;
                #1;
                for (int k = 0; k < 8; k++)
                    check_eq($sformatf("rst_async_out%0d", k + 1), w_out[k], 8'h00);
            end
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 8; k++) begin
                    p_mdl[d][k] = 8'h00;
                    p_spc[d][k] = 8'h00;
                end
                p_msk[d] = 8'hFF;
            end
        end else begin
            rst_n = 1'b1;
            fft_ref(x, y);
            for (int k = 0; k < 8; k++) begin
                p_mdl[0][k] = y[k];
                p_spc[0][k] = 8'(s[k]);
            end
            p_msk[0] = msk;
        end
    endtask

    task automatic rand_vec(output int x[8]);
        for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int xv [8];
        int sv [8];
        int zs [8];
        zs = '{default: 0};
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                p_mdl[d][k] = 8'h00;
                p_spc[d][k] = 8'h00;
            end
            p_msk[d] = 8'hFF;
        end
        rand_vec(xv);
        drive(xv);

        repeat (3) begin
            rand_vec(xv);
            cycle(xv, zs, 8'h00, 1'b1);
        end

        xv = '{64, 0, 0, 0, 0, 0, 0, 0};          sv = '{8, 8, 8, 8, 8, 8, 8, 8};
        cycle(xv, sv, 8'hFF, 1'b0);
        xv = '{16, 16, 16, 16, 16, 16, 16, 16};   sv = '{16, 0, 0, 0, 0, 0, 0, 0};
        cycle(xv, sv, 8'hFF, 1'b0);
        xv = '{16, -16, 16, -16, 16, -16, 16, -16}; sv = '{0, 0, 0, 0, 16, 0, 0, 0};
        cycle(xv, sv, 8'hFF, 1'b0);
        xv = '{0, 1, 2, 3, 4, 5, 6, 7};           sv = '{3, 0, -1, 0, -1, 0, -1, 0};
        cycle(xv, sv, 8'h55, 1'b0);
        xv = '{3, 2, 1, 8, 7, 4, 6, 5};           sv = '{4, 0, 0, 0, 0, 0, 0, 0};
        cycle(xv, sv, 8'h01, 1'b0);
        xv = '{7, 6, 5, 4, 3, 2, 1, 0};           sv = '{3, 0, 0, 0, 0, 0, 0, 0};
        cycle(xv, sv, 8'h01, 1'b0);
        rand_vec(xv);
        cycle(xv, zs, 8'h00, 1'b0);
        xv = '{0, 64, 0, 0, 0, 0, 0, 0};          sv = '{8, 0, 0, 0, -8, 0, 0, 0};
        cycle(xv, sv, 8'h55, 1'b0);
        xv = '{-128, -128, -128, -128, -128, -128, -128, -128}; sv = '{-128, 0, 0, 0, 0, 0, 0, 0};
        cycle(xv, sv, 8'hFF, 1'b0);
        xv = '{127, 127, 127, 127, 127, 127, 127, 127};         sv = '{127, 0, 0, 0, 0, 0, 0, 0};
        cycle(xv, sv, 8'hFF, 1'b0);

        repeat (40) begin
            rand_vec(xv);
            cycle(xv, zs, 8'h00, 1'b0);
        end

        repeat (2) begin
            rand_vec(xv);
            cycle(xv, zs, 8'h00, 1'b1);
        end
        repeat (10) begin
            rand_vec(xv);
            cycle(xv, zs, 8'h00, 1'b0);
        end
        repeat (3) begin
            rand_vec(xv);
            cycle(xv, zs, 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
